branch_npc_unit: RTL and testbench

- Fetch-PC generator and branch/jump resolution stage.
- Sits directly downstream of the ID-stage comparator.
- Consumes the comparator flags plus the branch/jump decode from ID, decides taken/not-taken, and owns the IF program-counter register.
- Handles delayed-branch semantics, pipeline stall, and a one-entry pending redirect for when instruction fetch is not ready.

---
 rtl/branch_npc_unit_if.sv | 42 ++++
 rtl/branch_npc_unit.sv | 156 +++++++++++++++
 tb/tb_branch_npc_unit.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/branch_npc_unit_if.sv
// ---------------------------------------------------------------------------
// branch_npc_unit_if
// Bundle between the ID stage, the hazard unit and instruction fetch on one
// side, and the branch/next-PC unit on the other.
//   master : drives the ID-stage decode, comparator flags, stall and if_ready.
//            Observes pc, taken, link_pc and pending.
//   slave  : the branch/next-PC unit itself.
// ---------------------------------------------------------------------------
interface branch_npc_unit_if;
   logic        stall;
   logic        if_ready;
   logic        br_valid;
   logic [2:0]  br_type;
   logic        zero;
   logic        budengyu;
   logic        xiaoyudengyu_zero;
   logic        dayu_zero;
   logic        xiaoyu_zero;
   logic        dayudengyu_zero;
   logic [31:0] pc_id;
   logic [15:0] imm16;
   logic [25:0] instr_index;
   logic [31:0] jr_target;
   logic [31:0] pc;
   logic        taken;
   logic [31:0] link_pc;
   logic        pending;

   modport master (
      output stall, if_ready, br_valid, br_type,
      output zero, budengyu, xiaoyudengyu_zero, dayu_zero, xiaoyu_zero, dayudengyu_zero,
      output pc_id, imm16, instr_index, jr_target,
      input  pc, taken, link_pc, pending
   );

   modport slave (
      input  stall, if_ready, br_valid, br_type,
      input  zero, budengyu, xiaoyudengyu_zero, dayu_zero, xiaoyu_zero, dayudengyu_zero,
      input  pc_id, imm16, instr_index, jr_target,
      output pc, taken, link_pc, pending
   );
endinterface

// File: rtl/branch_npc_unit.sv
// ---------------------------------------------------------------------------
// branch_npc_unit
// Owns the IF program counter and resolves branches/jumps held in ID.
// Delayed-branch machine: while the branch sits in ID, IF is already fetching
// its delay slot, so a taken redirect simply replaces the next PC update.
// When fetch cannot accept the redirect, the target is parked in a one-entry
// pending register (state HOLD) until if_ready arrives.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : slave side of branch_npc_unit_if
//           inputs  stall, if_ready, br_valid, br_type, comparator flags,
//                   pc_id, imm16, instr_index, jr_target
//           outputs pc (registered), taken (comb), link_pc (comb),
//                   pending (registered)
// ---------------------------------------------------------------------------
module branch_npc_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic             clk,
   input  logic             reset,
   branch_npc_unit_if.slave bus
);

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_HOLD = 1'b1
   } state_e;

   localparam logic [2:0] BT_BEQ  = 3'd0;
   localparam logic [2:0] BT_BNE  = 3'd1;
   localparam logic [2:0] BT_BLEZ = 3'd2;
   localparam logic [2:0] BT_BGTZ = 3'd3;
   localparam logic [2:0] BT_BLTZ = 3'd4;
   localparam logic [2:0] BT_BGEZ = 3'd5;
   localparam logic [2:0] BT_J    = 3'd6;
   localparam logic [2:0] BT_JR   = 3'd7;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pend_target_q, pend_target_d;

   logic        cond_s;
   logic        taken_s;
   logic [31:0] pc_id_plus4_s;
   logic [31:0] target_s;

   // Map the branch type onto the comparator flag that decides it.
   function automatic logic cond_sel(
      input logic [2:0] t,
      input logic       f_eq,
      input logic       f_ne,
      input logic       f_lez,
      input logic       f_gtz,
      input logic       f_ltz,
      input logic       f_gez
   );
      case (t)
         BT_BEQ:      cond_sel = f_eq;
         BT_BNE:      cond_sel = f_ne;
         BT_BLEZ:     cond_sel = f_lez;
         BT_BGTZ:     cond_sel = f_gtz;
         BT_BLTZ:     cond_sel = f_ltz;
         BT_BGEZ:     cond_sel = f_gez;
         BT_J, BT_JR: cond_sel = 1'b1;
         default:     cond_sel = 1'b0;
      endcase
   endfunction

   // Redirect target; all arithmetic wraps modulo 2^32.
   function automatic logic [31:0] target_sel(
      input logic [2:0]  t,
      input logic [31:0] plus4,
      input logic [15:0] imm,
      input logic [25:0] idx,
      input logic [31:0] jr
   );
      case (t)
         BT_J:    target_sel = {plus4[31:28], idx, 2'b00};
         // Register targets are forced word aligned.
         BT_JR:   target_sel = jr & 32'hFFFF_FFFC;
         default: target_sel = plus4 + {{14{imm[15]}}, imm, 2'b00};
      endcase
   endfunction

   assign pc_id_plus4_s = bus.pc_id + 32'd4;
   assign cond_s        = cond_sel(bus.br_type, bus.zero, bus.budengyu,
                                   bus.xiaoyudengyu_zero, bus.dayu_zero,
                                   bus.xiaoyu_zero, bus.dayudengyu_zero);
   assign target_s      = target_sel(bus.br_type, pc_id_plus4_s, bus.imm16,
                                     bus.instr_index, bus.jr_target);

   // State register: PC, FSM state and parked redirect target.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_RUN;
         pc_q          <= RESET_PC;
         pend_target_q <= 32'h0000_0000;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         pend_target_q <= pend_target_d;
      end
   end

   // Next-state logic: PC update, redirect parking and release.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      pend_target_d = pend_target_q;
      case (state_q)
         ST_RUN: begin
            if (bus.stall) begin
               pc_d = pc_q;
            end else if (taken_s && bus.if_ready) begin
               pc_d = target_s;
            end else if (taken_s) begin
               pend_target_d = target_s;
               state_d       = ST_HOLD;
            end else if (bus.if_ready) begin
               pc_d = pc_q + 32'd4;
            end else begin
               pc_d = pc_q;
            end
         end
         ST_HOLD: begin
            if (bus.if_ready && !bus.stall) begin
               pc_d    = pend_target_q;
               state_d = ST_RUN;
            end else begin
               state_d = ST_HOLD;
            end
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   // Output decode: the branch already retired from ID while in HOLD, so taken
   // is suppressed there; stale operands under stall are never evaluated.
   always_comb begin
      taken_s = 1'b0;
      if ((state_q == ST_RUN) && bus.br_valid && !bus.stall) begin
         taken_s = cond_s;
      end else begin
         taken_s = 1'b0;
      end
   end

   assign bus.pc      = pc_q;
   assign bus.pending = (state_q == ST_HOLD);
   assign bus.taken   = taken_s;
   assign bus.link_pc = bus.pc_id + 32'd8;

endmodule

// File: tb/tb_branch_npc_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_npc_unit
// Directed vectors for branch_npc_unit. Each driven cycle pushes the values
// expected at the following falling edge (current pc/pending plus the
// combinational taken/link_pc); a monitor pops and compares on every falling
// edge. pc after a clock edge is checked by the next cycle's entry.
// ---------------------------------------------------------------------------
module tb_branch_npc_unit;

   typedef struct {
      string       name;
      logic [31:0] pc;
      logic        pend;
      logic        tk;
      logic        chk_link;
      logic [31:0] link;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;
   exp_t sb_q[$];

   branch_npc_unit_if bus ();

   branch_npc_unit #(.RESET_PC(32'h0000_3000)) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string what, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", what, act, exp);
      end
   endtask

   // Monitor: compare DUT state against the scoreboard on every falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({e.name, ".pc"}, bus.pc, e.pc);
            chk({e.name, ".pending"}, {31'd0, bus.pending}, {31'd0, e.pend});
            chk({e.name, ".taken"}, {31'd0, bus.taken}, {31'd0, e.tk});
            if (e.chk_link) chk({e.name, ".link_pc"}, bus.link_pc, e.link);
         end
      end
   end

   task automatic set_idle();
      bus.stall             = 1'b0;
      bus.if_ready          = 1'b1;
      bus.br_valid          = 1'b0;
      bus.br_type           = 3'd0;
      bus.zero              = 1'b0;
      bus.budengyu          = 1'b0;
      bus.xiaoyudengyu_zero = 1'b0;
      bus.dayu_zero         = 1'b0;
      bus.xiaoyu_zero       = 1'b0;
      bus.dayudengyu_zero   = 1'b0;
      bus.pc_id             = 32'h0;
      bus.imm16             = 16'h0;
      bus.instr_index       = 26'h0;
      bus.jr_target         = 32'h0;
   endtask

   // Push expectation for the current cycle, then advance to posedge + 1.
   task automatic cyc(input string name, input logic [31:0] epc, input logic epend,
                      input logic etk, input logic chk_l, input logic [31:0] elink);
      exp_t e;
      e.name = name; e.pc = epc; e.pend = epend; e.tk = etk;
      e.chk_link = chk_l; e.link = elink;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      set_idle();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Sequential fetch out of reset.
      cyc("reset0", 32'h0000_3000, 1'b0, 1'b0, 1'b0, 32'h0);
      cyc("seq1",   32'h0000_3004, 1'b0, 1'b0, 1'b0, 32'h0);

      // BEQ taken: 0x3010 + 4 + (4 << 2) = 0x3024.
      bus.br_valid = 1'b1; bus.br_type = 3'd0; bus.zero = 1'b1;
      bus.pc_id = 32'h0000_3010; bus.imm16 = 16'h0004;
      cyc("beq_taken", 32'h0000_3008, 1'b0, 1'b1, 1'b1, 32'h0000_3018);

      // BNE backward: 0x3024 - 16 = 0x3014.
      set_idle();
      bus.br_valid = 1'b1; bus.br_type = 3'd1; bus.budengyu = 1'b1;
      bus.pc_id = 32'h0000_3020; bus.imm16 = 16'hFFFC;
      cyc("bne_back", 32'h0000_3024, 1'b0, 1'b1, 1'b1, 32'h0000_3028);

      // BNE not taken: sequential increment.
      bus.budengyu = 1'b0;
      cyc("bne_nt", 32'h0000_3014, 1'b0, 1'b0, 1'b1, 32'h0000_3028);

      // Jump type with br_valid low never reports taken.
      set_idle();
      bus.br_type = 3'd6;
      cyc("nobr_j", 32'h0000_3018, 1'b0, 1'b0, 1'b0, 32'h0);

      // Stalled BGTZ: target 0x3104 + 0x40 = 0x3144 only after stall drops.
      set_idle();
      bus.stall = 1'b1; bus.br_valid = 1'b1; bus.br_type = 3'd3; bus.dayu_zero = 1'b1;
      bus.pc_id = 32'h0000_3100; bus.imm16 = 16'h0010;
      cyc("stall0", 32'h0000_301C, 1'b0, 1'b0, 1'b1, 32'h0000_3108);
      cyc("stall1", 32'h0000_301C, 1'b0, 1'b0, 1'b0, 32'h0);
      bus.stall = 1'b0;
      cyc("unstall", 32'h0000_301C, 1'b0, 1'b1, 1'b0, 32'h0);

      // Fetch not ready, no branch: pc holds.
      set_idle();
      bus.if_ready = 1'b0;
      cyc("ifnr_hold", 32'h0000_3144, 1'b0, 1'b0, 1'b0, 32'h0);

      // JR with fetch not ready parks the aligned target 0x4000.
      bus.br_valid = 1'b1; bus.br_type = 3'd7; bus.jr_target = 32'h0000_4003;
      bus.pc_id = 32'h0000_3200;
      cyc("jr_park", 32'h0000_3144, 1'b0, 1'b1, 1'b1, 32'h0000_3208);
      cyc("hold1", 32'h0000_3144, 1'b1, 1'b0, 1'b0, 32'h0);
      bus.br_valid = 1'b0;
      cyc("hold2", 32'h0000_3144, 1'b1, 1'b0, 1'b0, 32'h0);
      bus.br_valid = 1'b1; bus.stall = 1'b1; bus.if_ready = 1'b1;
      cyc("hold_stall", 32'h0000_3144, 1'b1, 1'b0, 1'b0, 32'h0);
      bus.br_valid = 1'b0; bus.stall = 1'b0;
      cyc("release", 32'h0000_3144, 1'b1, 1'b0, 1'b0, 32'h0);

      // J: {0x4, 0x100, 00} = 0x4000_0400.
      set_idle();
      bus.br_valid = 1'b1; bus.br_type = 3'd6;
      bus.pc_id = 32'h3FFF_FFFC; bus.instr_index = 26'h0000100;
      cyc("j_region", 32'h0000_4000, 1'b0, 1'b1, 1'b1, 32'h4000_0004);

      // JR to top of address space, then sequential wrap.
      set_idle();
      bus.br_valid = 1'b1; bus.br_type = 3'd7; bus.jr_target = 32'hFFFF_FFFE;
      cyc("jr_top", 32'h4000_0400, 1'b0, 1'b1, 1'b0, 32'h0);
      set_idle();
      cyc("top", 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 32'h0);

      // Enter HOLD again, then reset between edges.
      bus.br_valid = 1'b1; bus.br_type = 3'd7; bus.jr_target = 32'h0000_5000;
      bus.if_ready = 1'b0;
      cyc("wrap_park", 32'h0000_0000, 1'b0, 1'b1, 1'b0, 32'h0);
      set_idle();
      bus.if_ready = 1'b0;
      cyc("hold_pre_rst", 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0);
      rst_n = 1'b0;
      cyc("async_rst", 32'h0000_3000, 1'b0, 1'b0, 1'b0, 32'h0);
      rst_n = 1'b1;
      bus.if_ready = 1'b1;
      cyc("post_rst", 32'h0000_3000, 1'b0, 1'b0, 1'b0, 32'h0);
      cyc("post_rst_seq", 32'h0000_3004, 1'b0, 1'b0, 1'b0, 32'h0);

      // Drain the scoreboard within a bounded number of cycles.
      for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge clk);
      n_checks++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d entries left expected 0", sb_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
